// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the single-port main RAM: the CPU has priority, and the external
// port uses idle cycles. A one-cycle CPU hold guarantees the external port eventually gets in.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_hold,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  ram_en_read,
  output logic                  ram_en_write,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [1:0]            arb_state
);

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_HOLD = 2'd1
  } state_e;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d, wait_inc_s;
  logic       ext_rvalid_q, ext_rvalid_d;
  logic       cpu_acc_s;

  assign cpu_acc_s  = cpu_rd | cpu_wr;
  assign wait_inc_s = (wait_cnt_q == 8'hFF) ? 8'hFF : (wait_cnt_q + 8'd1);

  // Only one access hits the RAM per cycle, so return data can be shared by both requesters.
  assign cpu_rdata  = ram_rdata;
  assign ext_rdata  = ram_rdata;
  assign arb_state  = state_q;
  assign cpu_hold   = (state_q == S_HOLD) & ~reset;
  assign ext_rvalid = ext_rvalid_q & ~reset;

  always_comb begin
    ram_en_read  = 1'b0;
    ram_en_write = 1'b0;
    ram_addr     = cpu_addr;
    ram_wdata    = cpu_wdata;
    ext_gnt      = 1'b0;
    state_d      = S_CPU;
    wait_cnt_d   = 8'd0;
    ext_rvalid_d = 1'b0;
    case (state_q)
      S_CPU: begin
        if (cpu_acc_s) begin
          // A simultaneous read and write strobe is resolved as a write.
          ram_en_write = cpu_wr;
          ram_en_read  = cpu_rd & ~cpu_wr;
          if (ext_req) begin
            wait_cnt_d = wait_inc_s;
            if (wait_inc_s >= MAX_WAIT_C) begin
              state_d = S_HOLD;
            end else begin
              state_d = S_CPU;
            end
          end else begin
            wait_cnt_d = 8'd0;
          end
        end else if (ext_req) begin
          ram_addr     = ext_addr;
          ram_wdata    = ext_wdata;
          ram_en_write = ext_we;
          ram_en_read  = ~ext_we;
          ext_gnt      = 1'b1;
          ext_rvalid_d = ~ext_we;
        end else begin
          wait_cnt_d = 8'd0;
        end
      end
      S_HOLD: begin
        // CPU is frozen; it re-presents the same access next cycle and wins then.
        ram_addr     = ext_addr;
        ram_wdata    = ext_wdata;
        ram_en_write = ext_req & ext_we;
        ram_en_read  = ext_req & ~ext_we;
        ext_gnt      = ext_req;
        ext_rvalid_d = ext_req & ~ext_we;
      end
      default: begin
        state_d = S_CPU;
      end
    endcase
    if (reset) begin
      ram_en_read  = 1'b0;
      ram_en_write = 1'b0;
      ext_gnt      = 1'b0;
    end else begin
      ext_gnt = ext_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CPU;
      wait_cnt_q   <= 8'd0;
      ext_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a scoreboard of expected ext read data.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_hold;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [15:0] ext_rdata;
  logic        ram_en_read, ram_en_write;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0]  arb_state;

  logic [15:0] mem [0:1023];
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_en_read(ram_en_read), .ram_en_write(ram_en_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency; 0x0040 is preloaded while reset is high.
  always @(posedge clk) begin
    if (ram_en_write) mem[ram_addr[9:0]] <= ram_wdata;
    if (ram_en_read) ram_rdata <= mem[ram_addr[9:0]];
    if (reset) mem[10'h040] <= 16'hBEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=rvalid expected=no_pending_read", tag);
    end else begin
      chk(tag, {16'd0, ext_rdata}, {16'd0, exp_q.pop_front()});
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] ca, input logic [15:0] cd,
                       input logic rq, input logic we, input logic [15:0] ea, input logic [15:0] ed);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = ca; cpu_wdata = cd;
    ext_req = rq; ext_we = we; ext_addr = ea; ext_wdata = ed;
  endtask

  logic [15:0] rb_addr [0:5];
  logic [15:0] rb_exp  [0:5];

  initial begin
    rb_addr[0] = 16'h0100; rb_exp[0] = 16'hA000;
    rb_addr[1] = 16'h0101; rb_exp[1] = 16'hA001;
    rb_addr[2] = 16'h0102; rb_exp[2] = 16'hA002;
    rb_addr[3] = 16'h0103; rb_exp[3] = 16'hA003;
    rb_addr[4] = 16'h0010; rb_exp[4] = 16'h1234;
    rb_addr[5] = 16'h0020; rb_exp[5] = 16'h5555;

    // Reset with both requesters active
    reset = 1'b1;
    drive(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);
    repeat (3) begin
      next_cycle();
      @(negedge clk);
      chk("rst_en_read", ram_en_read, 1'b0);
      chk("rst_en_write", ram_en_write, 1'b0);
      chk("rst_gnt", ext_gnt, 1'b0);
      chk("rst_hold", cpu_hold, 1'b0);
      chk("rst_state", arb_state, 2'd0);
      chk("rst_rvalid", ext_rvalid, 1'b0);
    end

    // Release: CPU read wins over the pending ext request
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rel_cpu_read", ram_en_read, 1'b1);
    chk("rel_addr", ram_addr, 16'h0005);
    chk("rel_gnt", ext_gnt, 1'b0);

    // CPU idle: ext read of 0x0040 granted immediately
    next_cycle();
    drive(1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);
    exp_q.push_back(16'hBEEF);
    @(negedge clk);
    chk("extrd_gnt", ext_gnt, 1'b1);
    chk("extrd_en_read", ram_en_read, 1'b1);
    chk("extrd_addr", ram_addr, 16'h0040);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("extrd_rvalid", ext_rvalid, 1'b1);
    chk("extrd_cpu_rdata", cpu_rdata, 16'hBEEF);
    pop_chk("extrd_rdata");

    // CPU writes for 3 cycles with an ext write pending: below MAX_WAIT, no hold
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b1, 1'b1, 16'h0020, 16'h5555);
      @(negedge clk);
      chk("cpuwr_en_write", ram_en_write, 1'b1);
      chk("cpuwr_addr", ram_addr, 16'h0010);
      chk("cpuwr_wdata", ram_wdata, 16'h1234);
      chk("cpuwr_gnt", ext_gnt, 1'b0);
      chk("cpuwr_hold", cpu_hold, 1'b0);
    end
    next_cycle();
    drive(1'b0, 1'b0, 16'h0010, 16'h1234, 1'b1, 1'b1, 16'h0020, 16'h5555);
    @(negedge clk);
    chk("idle_gnt", ext_gnt, 1'b1);
    chk("idle_addr", ram_addr, 16'h0020);
    chk("idle_wdata", ram_wdata, 16'h5555);
    chk("idle_en_write", ram_en_write, 1'b1);
    chk("idle_en_read", ram_en_read, 1'b0);

    // CPU reads every cycle with ext read held: hold appears after exactly 4 blocked cycles
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);
      @(negedge clk);
      chk("blk_gnt", ext_gnt, 1'b0);
      chk("blk_hold", cpu_hold, 1'b0);
      chk("blk_addr", ram_addr, 16'h0030);
    end
    next_cycle();
    exp_q.push_back(16'hBEEF);
    @(negedge clk);
    chk("hold_hold", cpu_hold, 1'b1);
    chk("hold_state", arb_state, 2'd1);
    chk("hold_gnt", ext_gnt, 1'b1);
    chk("hold_addr", ram_addr, 16'h0040);
    chk("hold_en_read", ram_en_read, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("after_hold", cpu_hold, 1'b0);
    chk("after_state", arb_state, 2'd0);
    chk("after_addr", ram_addr, 16'h0030);
    chk("after_en_read", ram_en_read, 1'b1);
    chk("after_rvalid", ext_rvalid, 1'b1);
    pop_chk("hold_rdata");

    // Back-to-back ext writes with CPU idle
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, rb_addr[i], rb_exp[i]);
      @(negedge clk);
      chk("b2b_gnt", ext_gnt, 1'b1);
      chk("b2b_addr", ram_addr, rb_addr[i]);
      chk("b2b_en_write", ram_en_write, 1'b1);
    end

    // Back-to-back readback, including the CPU-written and ext-written words
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, rb_addr[i], 16'h0000);
      exp_q.push_back(rb_exp[i]);
      @(negedge clk);
      chk("rb_gnt", ext_gnt, 1'b1);
      chk("rb_en_read", ram_en_read, 1'b1);
      if (i > 0) begin
        chk("rb_rvalid", ext_rvalid, 1'b1);
        pop_chk("rb_rdata");
      end
    end
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("rb_last_rvalid", ext_rvalid, 1'b1);
    pop_chk("rb_last_rdata");

    // Reset in the cycle after a granted ext read drops the return
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);
    @(negedge clk);
    chk("drop_gnt", ext_gnt, 1'b1);
    next_cycle();
    reset = 1'b1;
    drive(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("drop_rvalid", ext_rvalid, 1'b0);
    chk("drop_en_read", ram_en_read, 1'b0);
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    chk("drop_state", arb_state, 2'd0);
    chk("drop_rvalid2", ext_rvalid, 1'b0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
